// File: rtl/compare_pkg.sv
// Shared types for the digit-serial magnitude comparator.
package compare_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
  } result_t;

  // Number of DIGIT-wide slices in a WIDTH-bit operand.
  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/digit_compare.sv
// Combinational unsigned compare of one DIGIT-bit slice.
module digit_compare #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  // Narrow compare only; the parent walks the operand one slice at a time.
  always_comb begin
    lt = (a < b);
    gt = (a > b);
    eq = (a == b);
  end

endmodule

// File: rtl/serial_compare.sv
// Digit-serial MSB-first magnitude comparator with early exit.
// Optional feature: define COMPARE_SIGNED_EN to add a signed_mode input
// that treats operands as two's complement.
module serial_compare
  import compare_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef COMPARE_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             AltB,
  output logic             AbtB,
  output logic             AeqB
);

  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % DIGIT) != 0 || DIGIT < 1) begin : g_bad_cfg
    $error("serial_compare: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa, sb;
  result_t          res;
  logic [DIGIT-1:0] da, db;
  logic             dlt, dgt, deq;
  logic             accept;

  // start is only taken when the block can begin a new compare.
  assign accept = en && start && (state == IDLE || state == DONE);

`ifdef COMPARE_SIGNED_EN
  logic sgn;

  // Signed mode travels with the operands it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         sgn <= 1'b0;
    else if (accept) sgn <= signed_mode;
  end

  // Flipping the sign bits of the top slice turns the unsigned compare signed.
  always_comb begin
    da = sa[WIDTH-1 -: DIGIT];
    db = sb[WIDTH-1 -: DIGIT];
    if (sgn && cnt == LAST) begin
      da[DIGIT-1] = ~da[DIGIT-1];
      db[DIGIT-1] = ~db[DIGIT-1];
    end
  end
`else
  assign da = sa[WIDTH-1 -: DIGIT];
  assign db = sb[WIDTH-1 -: DIGIT];
`endif

  digit_compare #(.DIGIT(DIGIT)) u_dig (
    .a  (da),
    .b  (db),
    .lt (dlt),
    .gt (dgt),
    .eq (deq)
  );

  // FSM, operand shifters, digit counter and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            sa    <= A;
            sb    <= B;
            cnt   <= LAST;
            res   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (en) begin
            if (!deq) begin
              res   <= '{lt: dlt, gt: dgt, eq: 1'b0};
              state <= DONE;
            end else if (cnt == '0) begin
              res   <= '{lt: 1'b0, gt: 1'b0, eq: 1'b1};
              state <= DONE;
            end else begin
              sa  <= sa << DIGIT;
              sb  <= sb << DIGIT;
              cnt <= cnt - CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign AltB = res.lt;
  assign AbtB = res.gt;
  assign AeqB = res.eq;

endmodule

// File: doc/serial_compare.md
# serial_compare

Parametrised, digit-serial magnitude comparator for two WIDTH-bit operands. It works MSB-first, DIGIT bits per clock, and stops as soon as a digit differs. Results are registered, one-hot, and held on AltB/AbtB/AeqB, so the block drops in wherever the single-bit combinational compare cell runs out of width. A start/busy/done handshake and an enable-driven stall make it usable on multi-cycle datapaths.

## Interface
- WIDTH, 16: operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4: bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  enable; low stalls the operation and blocks start.
- start  input  1  request a compare; sampled only when en=1 and the block is not busy.
- A  input  WIDTH  operand A; captured on an accepted start.
- B  input  WIDTH  operand B; captured on an accepted start.
- busy  output  1  a compare is in progress.
- done  output  1  one-cycle completion pulse.
- AltB  output  1  registered result A<B.
- AbtB  output  1  registered result A>B.
- AeqB  output  1  registered result A==B.

## Operation
- N = WIDTH/DIGIT digits. FSM states: IDLE, RUN, DONE.
- IDLE: if start&&en, capture A and B into shift registers, set digit counter to N-1, clear AltB/AbtB/AeqB to 0, go to RUN. Otherwise hold.
- RUN, en=1: compare the top DIGIT bits of both shift registers.
  - On mismatch, set AltB or AbtB and go to DONE (early termination).
  - On match with counter 0, set AeqB and go to DONE.
  - On match otherwise, shift left by DIGIT, decrement the counter, stay in RUN.
- RUN, en=0: the state, counter, shift registers and results all hold.
- DONE: done=1 for exactly one cycle, independent of en. Then go to IDLE. A start&&en sampled in DONE is accepted exactly as in IDLE.
- start while in RUN is ignored, with no queueing.
- The result flags are one-hot after every completion. They hold until the next accepted start clears them, and they are all-zero while busy.
- busy is high in RUN only. done and busy are never high together.
- Reset at any time, including mid-RUN, forces IDLE and drives busy, done, AltB, AbtB and AeqB to 0. The captured operands are discarded.

## Timing
- E0 is the edge that accepts start. busy rises after E0.
- Digit i (0 = most significant) is evaluated in the cycle after edge E(i), assuming no stalls.
- Mismatch at digit i: at E(i+1) the flag is set, done=1 and busy=0. done falls at E(i+2).
- All digits equal: AeqB and done are set at E(N).
- Latency from start to done is 1 cycle best case and N cycles worst case. Each cycle with en=0 in RUN adds exactly one cycle.
- Back-to-back throughput: a new start can be accepted on the edge that ends the done pulse.
- The comparison is combinational within one cycle across DIGIT bits only. There are no WIDTH-wide combinational paths after capture.

## Configuration
- COMPARE_SIGNED_EN defined:
  - Adds an input port signed_mode (1 bit), captured with the operands.
  - When signed_mode=1, operands are two's complement: in digit 0, the sign bit of each operand is inverted before comparing.
  - When signed_mode=0, the compare is unsigned.
- COMPARE_SIGNED_EN undefined: the signed_mode port is absent and the compare is always unsigned.

## Structure
- The package compare_pkg holds:
  - typedef state_t (enum IDLE, RUN, DONE);
  - typedef result_t (packed struct lt, gt, eq);
  - a function returning N for a given WIDTH and DIGIT.
- One sub-module, digit_compare: a combinational DIGIT-bit unsigned comparator. It takes a and b and returns lt, gt and eq, and is instantiated once. The signed adjustment is done by the parent.
- The parent holds the FSM, shift registers, counter and result register. Elaboration fails (an elaboration-time assertion) if WIDTH % DIGIT ≠ 0.

## Test plan
- Reset: hold rst=1 with random A, B, start and en → busy, done, AltB, AbtB and AeqB are all 0. Release reset → all stay 0 until a start.
- Equal operands: A=B=0x1234 with start → busy for 4 cycles, done pulses at E4, AeqB=1, AltB=AbtB=0, and the result holds afterwards.
- Early exit at the first digit: A=0x8000, B=0x7FFF → done at E1, AbtB=1 (unsigned). With COMPARE_SIGNED_EN and signed_mode=1 → done at E1, AltB=1.
- Late mismatch: A=0x12F0, B=0x12F1 → done at E4, AltB=1. Swap the operands → AbtB=1.
- Stall: A=0x1234, B=0x1235, with en=0 for 3 cycles after E1 → done at E7, AltB=1. start pulsed during RUN is ignored.
- Reset mid-RUN: assert rst at E2 of an equal compare → outputs are 0 immediately. A new start after release completes normally.
